led_pattern_gen: RTL
====================

# led_pattern_gen

Parametrised LED pattern engine driving `LED_NUM` board LEDs from the 50 MHz system clock. It generalises the fixed 4-LED demo into selectable patterns: blink, chase, bounce and binary count. It also has a runtime pause and an optional PWM "breathing" brightness overlay. It sits directly behind the LED pins; `mode` and `pause` come from board keys or switches and are synchronised inside.

## Interface
- `LED_NUM`, 4: number of LED outputs, ≥1.
- `CLK_FREQ_HZ`, 50_000_000: `sys_clk` frequency.
- `STEP_HZ`, 2: pattern steps per second.
  - `STEP_CYCLES = CLK_FREQ_HZ/STEP_HZ` (integer division), must be ≥2.
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; release is synchronous to `sys_clk`.
- `mode`  in  2  pattern select: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT. Asynchronous to `sys_clk`.
- `pause`  in  1  high freezes pattern stepping. Asynchronous to `sys_clk`.
- `led`  out  `LED_NUM`  LED drive, 1 = on. Registered.
- `step_pulse`  out  1  one-cycle strobe, high in the same cycle the pattern register takes a new step value. Registered.

## Operation
- `mode` and `pause` each pass through a 2-flop synchroniser (`mode_s`, `pause_s`). Synchroniser flops reset to 0.
- Divider `div_cnt`, width `$clog2(STEP_CYCLES)`:
  - counts 0..`STEP_CYCLES-1`, then wraps to 0;
  - tick = (`div_cnt == STEP_CYCLES-1`) && !`pause_s`;
  - while `pause_s` is high, `div_cnt` holds.
- Active mode register `mode_q` and pattern register `pat[LED_NUM-1:0]`. BOUNCE also uses direction flag `dir` (0 = left, toward MSB).
- Mode change takes priority over a simultaneous tick. When `mode_s != mode_q`, in that cycle:
  - `mode_q <= mode_s`, `div_cnt <= 0`;
  - `pat` is loaded with the mode's initial value: BLINK all-0, CHASE 1, BOUNCE 1 with `dir = 0`, COUNT 0;
  - `step_pulse` stays 0.
  - A mode change is still applied while paused.
- On each tick, per `mode_q`:
  - BLINK: `pat <= ~pat`.
  - CHASE: rotate left; the MSB wraps to bit 0.
  - BOUNCE: shift toward the MSB while `dir = 0`. When the shift places the 1 on the MSB, set `dir = 1`. Then shift toward the LSB until bit 0 is set, and set `dir = 0`. With `LED_NUM = 4` the sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - COUNT: `pat <= pat + 1`, modulo 2^`LED_NUM`. All-ones wraps to 0.
- With `LED_NUM = 1`, CHASE and BOUNCE hold at 1.
- Reset values: `div_cnt` 0, `mode_q` 0, `pat` 0, `dir` 0, `led` 0, `step_pulse` 0.
- Asserting `rst_n` mid-pattern returns everything to the reset values immediately, with no completion of the current step.

## Timing
- Input change to internal effect: `mode_s`/`pause_s` reflect an input change 2 rising edges after it is sampled.
- New mode's initial pattern appears on `led` 3 edges after the input change (4 with the overlay of the Configuration section compiled in).
- After a mode load or reset release, the first tick occurs when `div_cnt` reaches `STEP_CYCLES-1`. `pat` updates on the following edge, so the first step is `STEP_CYCLES` cycles after the load.
- Steady-state step period is exactly `STEP_CYCLES` cycles.
- Without the overlay, `led` equals `pat`. `step_pulse` is asserted in the same cycle that `pat`/`led` show the new value.
- `pause` deasserting resumes counting from the held `div_cnt` value, with no lost or extra step.

## Configuration
- `LED_BREATH_EN` defined:
  - adds an 8-bit free-running `pwm_cnt` and an 8-bit `duty` register;
  - `duty` ramps 0→255→0 as a triangle, changing by 1 each time `pwm_cnt` wraps from 255 to 0;
  - `led <= pat & {LED_NUM{pwm_cnt < duty}}`, registered, so `led` lags `pat` by one cycle;
  - `step_pulse` is delayed one cycle as well, to stay aligned with `led`;
  - reset: `pwm_cnt` 0, `duty` 0, ramp direction up;
  - the overlay keeps running while paused.
- `LED_BREATH_EN` undefined: none of this logic exists, and `led = pat`.

## Test plan
Bench parameters: `sys_clk` 20 ns period, `CLK_FREQ_HZ` = 20, `STEP_HZ` = 2, so `STEP_CYCLES` = 10.

1. Hold `rst_n` = 0 for 1000 ns with `mode` = 0. Check `led` = 0000 and `step_pulse` = 0 throughout. After release, `led` toggles 1111/0000 every 10 cycles, with `step_pulse` high for 1 cycle at each toggle.
2. Set `mode` = 1. Check `led` = 0001 3 cycles later. Then 0010, 0100, 1000, 0001 at 10-cycle intervals.
3. Set `mode` = 2. Check the sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with no repeated endpoint.
4. Set `mode` = 3 and run 16 steps. Check `led` counts 0→15, then wraps to 0000 on step 16.
5. In CHASE, assert `pause` for 35 cycles mid-step. Check `led` is frozen and `step_pulse` stays 0. After release, the next step occurs after exactly the remaining `div_cnt` cycles. Change `mode` while paused: check the new initial pattern loads.
6. Drop `rst_n` mid-COUNT at `led` = 0101. Check `led` = 0000 asynchronously, before the next clock edge. With `LED_BREATH_EN` defined, in CHASE: check `led` is 0 while `duty` = 0, and the fraction of cycles with the lit bit on rises over successive 256-cycle frames.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine (blink / chase / bounce / binary count)
// with a synchronised mode select and pause input.
// Optional PWM breathing overlay: define LED_BREATH_EN to compile it in.
module led_pattern_gen #(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned STEP_HZ     = 2
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    localparam int unsigned STEP_CYCLES = CLK_FREQ_HZ / STEP_HZ;
    localparam int unsigned DIV_W       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    // Synchroniser flops for the asynchronous key/switch inputs
    logic [1:0]         mode_meta_q, mode_s_q;
    logic               pause_meta_q, pause_s_q;

    // Pattern engine state
    logic [1:0]         mode_q,    mode_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [LED_NUM-1:0] pat_q,     pat_d;
    logic               dir_q,     dir_d;
    logic               step_q,    step_d;

    // Combinational helpers
    logic               mode_chg;
    logic               tick;
    logic [LED_NUM-1:0] pat_init;
    logic [LED_NUM-1:0] pat_step;
    logic               dir_step;

    // Two-flop synchronisers for mode and pause
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta_q  <= 2'd0;
            mode_s_q     <= 2'd0;
            pause_meta_q <= 1'b0;
            pause_s_q    <= 1'b0;
        end else begin
            mode_meta_q  <= mode;
            mode_s_q     <= mode_meta_q;
            pause_meta_q <= pause;
            pause_s_q    <= pause_meta_q;
        end
    end

    // State register: divider, active mode, pattern, bounce direction, strobe
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_BLINK;
            div_cnt_q <= '0;
            pat_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            div_cnt_q <= div_cnt_d;
            pat_q     <= pat_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
        end
    end

    // Initial pattern for the mode about to be loaded
    always_comb begin
        pat_init = '0;
        case (mode_s_q)
            MODE_CHASE,
            MODE_BOUNCE: pat_init = LED_NUM'(1);
            default:     pat_init = '0;
        endcase
    end

    // Next pattern value for one step of the active mode
    always_comb begin
        pat_step = pat_q;
        dir_step = dir_q;
        case (mode_q)
            MODE_BLINK: pat_step = ~pat_q;
            MODE_CHASE: pat_step = (pat_q << 1) | (pat_q >> (LED_NUM - 1));
            MODE_BOUNCE: begin
                // A single LED cannot move, so it simply stays lit
                if (LED_NUM == 1) begin
                    pat_step = pat_q;
                end else if (!dir_q) begin
                    pat_step = pat_q << 1;
                    if (pat_step[LED_NUM-1]) begin
                        dir_step = 1'b1;
                    end
                end else begin
                    pat_step = pat_q >> 1;
                    if (pat_step[0]) begin
                        dir_step = 1'b0;
                    end
                end
            end
            MODE_COUNT: pat_step = pat_q + LED_NUM'(1);
            default:    pat_step = pat_q;
        endcase
    end

    // Next-state: a mode change wins over a tick and is honoured while paused
    always_comb begin
        mode_d    = mode_q;
        div_cnt_d = div_cnt_q;
        pat_d     = pat_q;
        dir_d     = dir_q;
        step_d    = 1'b0;

        mode_chg  = (mode_s_q != mode_q);
        tick      = (div_cnt_q == DIV_LAST) && !pause_s_q;

        if (mode_chg) begin
            mode_d    = mode_s_q;
            div_cnt_d = '0;
            pat_d     = pat_init;
            dir_d     = 1'b0;
        end else if (!pause_s_q) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                pat_d  = pat_step;
                dir_d  = dir_step;
                step_d = 1'b1;
            end
        end
    end

`ifdef LED_BREATH_EN
    // Breathing overlay: triangle duty ramp gating the pattern through PWM
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [7:0]         duty_q,    duty_d;
    logic               duty_up_q, duty_up_d;
    logic [LED_NUM-1:0] led_q,     led_d;
    logic               step_dly_q;

    // Overlay registers; free-running, independent of pause
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= 8'd0;
            duty_q     <= 8'd0;
            duty_up_q  <= 1'b1;
            led_q      <= '0;
            step_dly_q <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            duty_up_q  <= duty_up_d;
            led_q      <= led_d;
            step_dly_q <= step_q;
        end
    end

    // Duty moves by one per PWM frame, turning round at 255 and 0
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        duty_d    = duty_q;
        duty_up_d = duty_up_q;
        led_d     = pat_q & {LED_NUM{pwm_cnt_q < duty_q}};
        if (pwm_cnt_q == 8'hFF) begin
            if (duty_up_q) begin
                duty_d = duty_q + 8'd1;
                if (duty_q == 8'hFE) begin
                    duty_up_d = 1'b0;
                end
            end else begin
                duty_d = duty_q - 8'd1;
                if (duty_q == 8'h01) begin
                    duty_up_d = 1'b1;
                end
            end
        end
    end
`endif

    // Output mapping; every source here is a flop
    always_comb begin
`ifdef LED_BREATH_EN
        led        = led_q;
        step_pulse = step_dly_q;
`else
        led        = pat_q;
        step_pulse = step_q;
`endif
    end

endmodule
